// File: rtl/csr_sequencer_if.sv
// Request/response, CSR-file access and trap handoff bundle for csr_sequencer.
// master: the sequencer itself; slave: execute stage plus CSR file.
// No storage in the bundle; all flow control is the req/rsp valid-ready pairs.
interface csr_sequencer_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_insn;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_rs1_data;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [4:0]      rsp_rd;
    logic            rsp_rd_we;
    logic [XLEN-1:0] rsp_rd_data;
    logic            rsp_redirect;
    logic [XLEN-1:0] rsp_redirect_pc;

    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [1:0]      csr_op;
    logic [XLEN-1:0] csr_rdata;

    logic            trap;
    logic [3:0]      trap_cause;
    logic [XLEN-1:0] trap_value;
    logic [XLEN-1:0] trap_pc;
    logic            trap_handled;
    logic [XLEN-1:0] trap_target_pc;

    modport master (
        input  req_valid, req_insn, req_pc, req_rs1_data, rsp_ready,
               csr_rdata, trap_handled, trap_target_pc,
        output req_ready, rsp_valid, rsp_rd, rsp_rd_we, rsp_rd_data,
               rsp_redirect, rsp_redirect_pc, csr_addr, csr_wdata, csr_op,
               trap, trap_cause, trap_value, trap_pc
    );

    modport slave (
        output req_valid, req_insn, req_pc, req_rs1_data, rsp_ready,
               csr_rdata, trap_handled, trap_target_pc,
        input  req_ready, rsp_valid, rsp_rd, rsp_rd_we, rsp_rd_data,
               rsp_redirect, rsp_redirect_pc, csr_addr, csr_wdata, csr_op,
               trap, trap_cause, trap_value, trap_pc
    );
endinterface

// File: rtl/csr_sequencer.sv
// SYSTEM-instruction sequencer: drives CSR file access (Zicsr, MRET) and trap requests (ECALL, EBREAK, illegal).
// Latency: CSR/MRET 3 cycles min (accept, EXEC, RESP); traps 4+ cycles, TWAIT holds until trap_handled.
// Backpressure: req_ready only in IDLE; RESP holds all outputs until rsp_ready. Option: CSR_SEQ_RO_CHECK_EN.
module csr_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    csr_sequencer_if.master bus
);
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_SET   = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSN_MRET  = 32'h30200073;
    localparam logic [11:0] CSR_MEPC   = 12'h341;

`ifdef CSR_SEQ_RO_CHECK_EN
    localparam bit RO_CHECK = 1'b1;
`else
    localparam bit RO_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, EXEC, TRAP, TWAIT, RESP} state_t;
    typedef enum logic [1:0] {K_CSR, K_MRET, K_TRAP} kind_t;

    typedef struct packed {
        kind_t           kind;
        logic [1:0]      op;
        logic [11:0]     addr;
        logic [XLEN-1:0] wdata;
        logic [3:0]      cause;
        logic [XLEN-1:0] tval;
        logic [4:0]      rd;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] insn, input logic [XLEN-1:0] rs1);
        dec_t d;
        d       = '0;
        d.kind  = K_TRAP;
        d.cause = CAUSE_ILLEGAL;
        d.tval  = XLEN'(insn);
        if (insn[6:0] == OPC_SYSTEM) begin
            case (insn[14:12])
                3'b000: begin
                    if (insn[31:7] == 25'd0) begin
                        d.cause = CAUSE_ECALL_M;
                        d.tval  = '0;
                    end else if (insn[31:7] == 25'h0002000) begin
                        d.cause = CAUSE_BREAKPOINT;
                        d.tval  = '0;
                    end else if (insn == INSN_MRET) begin
                        d.kind  = K_MRET;
                        d.cause = '0;
                        d.tval  = '0;
                        d.addr  = CSR_MEPC;
                    end
                end
                3'b100: d.cause = CAUSE_ILLEGAL;
                default: begin
                    d.kind  = K_CSR;
                    d.cause = '0;
                    d.tval  = '0;
                    d.addr  = insn[31:20];
                    d.rd    = insn[11:7];
                    d.wdata = insn[14] ? XLEN'(insn[19:15]) : rs1;
                    // SET/CLEAR with a zero source field must not write at all
                    case (insn[13:12])
                        2'b01:   d.op = OP_WRITE;
                        2'b10:   d.op = (insn[19:15] != 5'd0) ? OP_SET : OP_NOP;
                        default: d.op = (insn[19:15] != 5'd0) ? OP_CLEAR : OP_NOP;
                    endcase
                    if (RO_CHECK && d.op != OP_NOP && insn[31:30] == 2'b11) begin
                        d       = '0;
                        d.kind  = K_TRAP;
                        d.cause = CAUSE_ILLEGAL;
                        d.tval  = XLEN'(insn);
                    end
                end
            endcase
        end
        return d;
    endfunction

    state_t          state, state_nx;
    logic            live_q;
    dec_t            dec_q, dec_in;
    logic [XLEN-1:0] pc_q, data_q, redir_pc_q;
    logic            accept;

    assign dec_in = decode(bus.req_insn, bus.req_rs1_data);
    assign accept = (state == IDLE) && live_q && bus.req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            live_q     <= 1'b0;
            dec_q      <= '0;
            pc_q       <= '0;
            data_q     <= '0;
            redir_pc_q <= '0;
        end else begin
            state  <= state_nx;
            live_q <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    dec_q      <= dec_in;
                    pc_q       <= bus.req_pc;
                    data_q     <= '0;
                    redir_pc_q <= '0;
                end
                EXEC: begin
                    // csr_rdata is the pre-write value; the CSR file commits on this same edge
                    if (dec_q.kind == K_CSR)  data_q     <= bus.csr_rdata;
                    if (dec_q.kind == K_MRET) redir_pc_q <= bus.csr_rdata;
                end
                TWAIT: if (bus.trap_handled) redir_pc_q <= bus.trap_target_pc;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx            = state;
        bus.req_ready       = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_rd          = '0;
        bus.rsp_rd_we       = 1'b0;
        bus.rsp_rd_data     = '0;
        bus.rsp_redirect    = 1'b0;
        bus.rsp_redirect_pc = '0;
        bus.csr_addr        = '0;
        bus.csr_wdata       = '0;
        bus.csr_op          = OP_NOP;
        bus.trap            = 1'b0;
        bus.trap_cause      = '0;
        bus.trap_value      = '0;
        bus.trap_pc         = '0;
        case (state)
            IDLE: begin
                bus.req_ready = live_q;
                if (accept) state_nx = (dec_in.kind == K_TRAP) ? TRAP : EXEC;
            end
            EXEC: begin
                bus.csr_addr  = dec_q.addr;
                bus.csr_wdata = dec_q.wdata;
                bus.csr_op    = dec_q.op;
                state_nx      = RESP;
            end
            TRAP: begin
                bus.trap       = 1'b1;
                bus.trap_cause = dec_q.cause;
                bus.trap_value = dec_q.tval;
                bus.trap_pc    = pc_q;
                state_nx       = TWAIT;
            end
            TWAIT: if (bus.trap_handled) state_nx = RESP;
            RESP: begin
                bus.rsp_valid       = 1'b1;
                bus.rsp_rd          = dec_q.rd;
                bus.rsp_rd_we       = (dec_q.kind == K_CSR) && (dec_q.rd != 5'd0);
                bus.rsp_rd_data     = data_q;
                bus.rsp_redirect    = (dec_q.kind != K_CSR);
                bus.rsp_redirect_pc = redir_pc_q;
                if (bus.rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: directed vector table, reset corner sequences, then random SYSTEM instructions
// checked against a behavioural CSR/trap model; the bench also plays the CSR file and trap handler.
module tb_csr_sequencer;
    localparam int XLEN = 32;

`ifdef CSR_SEQ_RO_CHECK_EN
    localparam bit RO_EN = 1'b1;
`else
    localparam bit RO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    always #5 clk = ~clk;

    csr_sequencer_if #(.XLEN(XLEN)) bus ();
    csr_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    // CSR file stand-in: combinational read, write committed at the clock edge
    logic [31:0] csr_mem [0:4095];
    assign bus.csr_rdata      = csr_mem[bus.csr_addr];
    assign bus.trap_target_pc = csr_mem[12'h305];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= 32'h0;
            csr_mem[12'h301] <= 32'h40000100;
            csr_mem[12'h341] <= 32'h00000080;
        end else begin
            case (bus.csr_op)
                2'd1: csr_mem[bus.csr_addr] <= bus.csr_wdata;
                2'd2: csr_mem[bus.csr_addr] <= csr_mem[bus.csr_addr] | bus.csr_wdata;
                2'd3: csr_mem[bus.csr_addr] <= csr_mem[bus.csr_addr] & ~bus.csr_wdata;
                default: ;
            endcase
        end
    end

    logic any_out;
    assign any_out = |{bus.req_ready, bus.rsp_valid, bus.rsp_rd, bus.rsp_rd_we, bus.rsp_rd_data,
                       bus.rsp_redirect, bus.rsp_redirect_pc, bus.csr_addr, bus.csr_wdata, bus.csr_op,
                       bus.trap, bus.trap_cause, bus.trap_value, bus.trap_pc};

    typedef struct {
        logic [31:0] insn, pc, rs1;
        int          hold, thd, lat, act;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        trap;
        logic [3:0]  cause;
        logic [31:0] tval, tpc;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] rd_data;
        logic        redir;
        logic [31:0] redir_pc;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl [0:4095];
    vec_t        tbl [0:13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [11:0] csr, input logic [4:0] rs1f,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {csr, rs1f, f3, rd, 7'h73};
    endfunction

    function automatic vec_t mk(input logic [31:0] insn, pc, rs1, input int hold, thd, lat, act,
                                input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                                input logic trap, input logic [3:0] cause, input logic [31:0] tval, tpc,
                                input logic [4:0] rd, input logic rd_we, input logic [31:0] rd_data,
                                input logic redir, input logic [31:0] redir_pc);
        vec_t v;
        v.insn = insn; v.pc = pc; v.rs1 = rs1; v.hold = hold; v.thd = thd; v.lat = lat; v.act = act;
        v.op = op; v.addr = addr; v.wdata = wdata; v.trap = trap; v.cause = cause; v.tval = tval;
        v.tpc = tpc; v.rd = rd; v.rd_we = rd_we; v.rd_data = rd_data; v.redir = redir;
        v.redir_pc = redir_pc;
        return v;
    endfunction

    // Reference model: architectural effect of one SYSTEM instruction on the CSR array
    task automatic model(input logic [31:0] insn, pc, rs1, input int hold, thd, output vec_t v);
        logic [2:0]  f3;
        logic [11:0] a;
        logic [31:0] opnd, old;
        logic        writes;
        f3 = insn[14:12];
        a  = insn[31:20];
        v = mk(insn, pc, rs1, hold, thd, 2 + thd, 0, 2'd0, 12'h0, 32'h0,
               1'b1, 4'd2, insn, pc, 5'd0, 1'b0, 32'h0, 1'b1, 32'h0);
        if (insn[6:0] == 7'h73 && f3 != 3'd0 && f3 != 3'd4) begin
            opnd   = f3[2] ? {27'd0, insn[19:15]} : rs1;
            writes = (f3[1:0] == 2'b01) || (insn[19:15] != 5'd0);
            if (!(RO_EN && writes && a >= 12'hC00)) begin
                old     = mdl[a];
                v.trap  = 1'b0; v.cause = 4'd0; v.tval = 32'h0; v.tpc = 32'h0;
                v.lat   = 1;    v.redir = 1'b0;
                v.op    = writes ? f3[1:0] : 2'd0;
                v.addr  = a;    v.wdata = opnd;
                v.act   = (v.op != 2'd0 || a != 12'h0 || opnd != 32'h0) ? 1 : 0;
                v.rd    = insn[11:7];
                v.rd_we = (insn[11:7] != 5'd0);
                v.rd_data = old;
                if (writes) begin
                    case (f3[1:0])
                        2'b01:   mdl[a] = opnd;
                        2'b10:   mdl[a] = old | opnd;
                        default: mdl[a] = old & ~opnd;
                    endcase
                end
            end
        end else if (insn == 32'h00000073) begin
            v.cause = 4'd11; v.tval = 32'h0;
        end else if (insn == 32'h00100073) begin
            v.cause = 4'd3;  v.tval = 32'h0;
        end else if (insn == 32'h30200073) begin
            v.trap = 1'b0; v.cause = 4'd0; v.tval = 32'h0; v.tpc = 32'h0;
            v.lat  = 1;    v.act = 1;      v.addr = 12'h341;
            v.redir_pc = mdl[12'h341];
        end
        if (v.trap) v.redir_pc = mdl[12'h305];
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int          lat, act, tcnt, thc, guard;
        bit          waiting, hold_ok;
        logic [1:0]  o_op;
        logic [11:0] o_addr;
        logic [31:0] o_wdata, o_tval, o_tpc;
        logic [3:0]  o_cause;
        lat = 0; act = 0; tcnt = 0; thc = 0; guard = 0; waiting = 1'b0;
        o_op = '0; o_addr = '0; o_wdata = '0; o_tval = '0; o_tpc = '0; o_cause = '0;
        @(negedge clk);
        bus.req_insn = v.insn; bus.req_pc = v.pc; bus.req_rs1_data = v.rs1; bus.req_valid = 1'b1;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({nm, "/req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && lat < 60) begin
            if (bus.csr_op != 2'd0 || bus.csr_addr != 12'h0 || bus.csr_wdata != 32'h0) begin
                act++; o_op = bus.csr_op; o_addr = bus.csr_addr; o_wdata = bus.csr_wdata;
            end
            if (bus.trap) begin
                tcnt++; o_cause = bus.trap_cause; o_tval = bus.trap_value; o_tpc = bus.trap_pc;
                waiting = 1'b1; thc = v.thd; bus.trap_handled = 1'b0;
            end else if (waiting) begin
                if (thc == 0) bus.trap_handled = 1'b1;
                else thc--;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, "/latency"}, lat, v.lat);
        chk({nm, "/csr_cycles"}, act, v.act);
        chk({nm, "/trap_pulses"}, tcnt, v.trap ? 1 : 0);
        if (v.act > 0) begin
            chk({nm, "/csr_op"}, {30'd0, o_op}, {30'd0, v.op});
            chk({nm, "/csr_addr"}, {20'd0, o_addr}, {20'd0, v.addr});
            chk({nm, "/csr_wdata"}, o_wdata, v.wdata);
        end
        if (v.trap) begin
            chk({nm, "/trap_cause"}, {28'd0, o_cause}, {28'd0, v.cause});
            chk({nm, "/trap_value"}, o_tval, v.tval);
            chk({nm, "/trap_pc"}, o_tpc, v.tpc);
        end
        chk({nm, "/rsp_rd"}, {27'd0, bus.rsp_rd}, {27'd0, v.rd});
        chk({nm, "/rsp_rd_we"}, {31'd0, bus.rsp_rd_we}, {31'd0, v.rd_we});
        chk({nm, "/rsp_rd_data"}, bus.rsp_rd_data, v.rd_data);
        chk({nm, "/rsp_redirect"}, {31'd0, bus.rsp_redirect}, {31'd0, v.redir});
        chk({nm, "/rsp_redirect_pc"}, bus.rsp_redirect_pc, v.redir_pc);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            hold_ok = bus.rsp_valid && !bus.req_ready && bus.csr_op == 2'd0 && !bus.trap &&
                      bus.rsp_rd == v.rd && bus.rsp_rd_we == v.rd_we && bus.rsp_rd_data == v.rd_data &&
                      bus.rsp_redirect == v.redir && bus.rsp_redirect_pc == v.redir_pc;
            chk($sformatf("%s/hold%0d", nm, h), {31'd0, hold_ok}, 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.trap_handled = 1'b0;
        chk({nm, "/rsp_released"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
        if (v.act > 0) chk({nm, "/csr_state"}, csr_mem[v.addr], mdl[v.addr]);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [11:0] a;
        rst = 1'b1; mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_insn = '0; bus.req_pc = '0; bus.req_rs1_data = '0;
        bus.rsp_ready = 1'b0; bus.trap_handled = 1'b0;
        for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
        mdl[12'h301] = 32'h40000100;
        mdl[12'h341] = 32'h00000080;

        #1 chk("reset/outputs", {31'd0, any_out}, 32'd0);
        @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset/ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 chk("reset/ready_after_edge", {31'd0, bus.req_ready}, 32'd1);

        ins = enc(12'hC00, 5'd2, 3'd1, 5'd1);
        tbl[0]  = mk(enc(12'h305, 5'd1, 3'd1, 5'd5), 32'h100, 32'h10, 0, 0, 1, 1, 2'd1, 12'h305, 32'h10,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0, 32'h0);
        tbl[1]  = mk(enc(12'h305, 5'd0, 3'd2, 5'd6), 32'h104, 32'h0, 0, 0, 1, 1, 2'd0, 12'h305, 32'h0,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd6, 1'b1, 32'h10, 1'b0, 32'h0);
        tbl[2]  = mk(enc(12'h305, 5'd3, 3'd6, 5'd0), 32'h108, 32'hFFFF, 1, 0, 1, 1, 2'd2, 12'h305, 32'h3,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h10, 1'b0, 32'h0);
        tbl[3]  = mk(enc(12'h305, 5'd2, 3'd7, 5'd7), 32'h10C, 32'h0, 0, 0, 1, 1, 2'd3, 12'h305, 32'h2,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd7, 1'b1, 32'h13, 1'b0, 32'h0);
        tbl[4]  = mk(enc(12'h301, 5'd0, 3'd2, 5'd8), 32'h110, 32'h0, 0, 0, 1, 1, 2'd0, 12'h301, 32'h0,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd8, 1'b1, 32'h40000100, 1'b0, 32'h0);
        tbl[5]  = mk(enc(12'h305, 5'd3, 3'd1, 5'd0), 32'h114, 32'h10, 0, 0, 1, 1, 2'd1, 12'h305, 32'h10,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h11, 1'b0, 32'h0);
        tbl[6]  = mk(32'h00000073, 32'h20, 32'h0, 0, 0, 2, 0, 2'd0, 12'h0, 32'h0,
                     1'b1, 4'd11, 32'h0, 32'h20, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);
        tbl[7]  = mk(32'h00100073, 32'h24, 32'h0, 1, 2, 4, 0, 2'd0, 12'h0, 32'h0,
                     1'b1, 4'd3, 32'h0, 32'h24, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);
        if (RO_EN)
            tbl[8] = mk(ins, 32'h100, 32'h1234, 0, 0, 2, 0, 2'd0, 12'h0, 32'h0,
                        1'b1, 4'd2, ins, 32'h100, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);
        else
            tbl[8] = mk(ins, 32'h100, 32'h1234, 0, 0, 1, 1, 2'd1, 12'hC00, 32'h1234,
                        1'b0, 4'd0, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0, 1'b0, 32'h0);
        tbl[9]  = mk(32'h0000000F, 32'h40, 32'h0, 0, 0, 2, 0, 2'd0, 12'h0, 32'h0,
                     1'b1, 4'd2, 32'h0000000F, 32'h40, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);
        tbl[10] = mk(32'h30200073, 32'h44, 32'h0, 0, 0, 1, 1, 2'd0, 12'h341, 32'h0,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h80);
        tbl[11] = mk(enc(12'h305, 5'd0, 3'd2, 5'd9), 32'h118, 32'h0, 3, 0, 1, 1, 2'd0, 12'h305, 32'h0,
                     1'b0, 4'd0, 32'h0, 32'h0, 5'd9, 1'b1, 32'h10, 1'b0, 32'h0);
        ins = enc(12'h305, 5'd1, 3'd4, 5'd1);
        tbl[12] = mk(ins, 32'h48, 32'h5, 0, 1, 3, 0, 2'd0, 12'h0, 32'h0,
                     1'b1, 4'd2, ins, 32'h48, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);
        tbl[13] = mk(32'h10500073, 32'h4C, 32'h0, 0, 0, 2, 0, 2'd0, 12'h0, 32'h0,
                     1'b1, 4'd2, 32'h10500073, 32'h4C, 5'd0, 1'b0, 32'h0, 1'b1, 32'h10);

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].insn, tbl[i].pc, tbl[i].rs1, tbl[i].hold, tbl[i].thd, v);
            run_vec(tbl[i], $sformatf("dir%0d", i));
        end

        // Reset while the CSRRW is in EXEC: write must be suppressed
        @(negedge clk);
        bus.req_insn = enc(12'h305, 5'd1, 3'd1, 5'd1); bus.req_pc = 32'h200;
        bus.req_rs1_data = 32'hDEAD; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_exec/op_before", {30'd0, bus.csr_op}, 32'd1);
        rst = 1'b1;
        #1 chk("rst_exec/outputs", {31'd0, any_out}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_exec/ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 chk("rst_exec/ready_after_edge", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_exec/mtvec", csr_mem[12'h305], 32'h10);

        // Reset while waiting for a trap handler that never answers
        @(negedge clk);
        bus.req_insn = 32'h00000073; bus.req_pc = 32'h300; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_twait/trap", {31'd0, bus.trap}, 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_twait/waiting", {30'd0, bus.rsp_valid, bus.req_ready}, 32'd0);
        rst = 1'b1;
        #1 chk("rst_twait/outputs", {31'd0, any_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_twait/ready", {31'd0, bus.req_ready}, 32'd1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: a = 12'h305; 1: a = 12'h340; 2: a = 12'h341;
                3: a = 12'h300; 4: a = 12'hC00; default: a = 12'hF11;
            endcase
            case ($urandom_range(0, 5))
                0: f3 = 3'd1; 1: f3 = 3'd2; 2: f3 = 3'd3;
                3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
            endcase
            case ($urandom_range(0, 9))
                6: ins = 32'h00000073;
                7: ins = 32'h00100073;
                8: ins = 32'h30200073;
                9: begin
                    ins = $urandom;
                    if (ins[6:0] == 7'h73) ins[6:0] = 7'h33;
                end
                default: ins = enc(a, 5'($urandom_range(0, 3)), f3, 5'($urandom_range(0, 31)));
            endcase
            model(ins, $urandom & 32'hFFFFFFFC, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), v);
            run_vec(v, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
